linreg_engine: RTL
==================

Name: linreg_engine

Overview:
- Parametrised, self-sequenced least-squares linear-regression engine. Accepts a stream of N (x, y) samples over a valid/ready handshake and returns the signed fixed-point slope b1 and intercept b0.
- Replaces externally driven enable/mode datapaths with an internal FSM, a runtime sample count and a shared sequential divider.
- Sits between the sample source and the result consumer in the regression subsystem.

Parameters:
- DW, 20, unsigned width of xi/yi.
- N_MAX, 256, maximum samples per job.
- FRAC, 10, fractional bits of b0/b1.
- Derived localparams (package):
  - CW = clog2(N_MAX+1)
  - SW = DW+CW (sums)
  - QW = 2*DW+CW (sums of products)
  - PW = 2*DW+2*CW+1 (signed Sxx/Sxy)
  - DVW = PW+FRAC (divider width)
  - B1W = DVW
  - B0W = B1W+SW+1

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle job request, sampled only in IDLE.
- n_samples  in  CW  sample count, latched on accepted start.
- in_valid  in  1  sample valid.
- in_ready  out  1  engine can accept a sample.
- xi  in  DW  unsigned x sample.
- yi  in  DW  unsigned y sample.
- busy  out  1  high in every state except IDLE.
- out_valid  out  1  result valid, held until out_ready.
- out_ready  in  1  consumer accepts result.
- b1  out  B1W  signed slope, FRAC fractional bits.
- b0  out  B0W  signed intercept, FRAC fractional bits.
- err_div0  out  1  Sxx was zero; qualified by out_valid.

Behaviour:
- Reset (async, any state): FSM to IDLE. All accumulators, counters, b0, b1, err_div0, out_valid, in_ready and busy cleared to 0. Any job in flight is discarded.
- FSM states: IDLE, ACC, CALC, DIV1, MUL, DIV0, DONE.
- IDLE:
  - start=1 and n_samples>0: clear Σx, Σy, Σx², Σxy and the count; latch N; go to ACC.
  - start=1 and n_samples=0: go to DONE with b0=b1=0 and err_div0=1.
  - start outside IDLE is ignored.
- ACC:
  - in_ready=1. A transfer occurs when in_valid & in_ready. Each transfer adds x, y, x*x, x*y (all unsigned) and increments the count.
  - After the Nth transfer, in_ready drops in the same cycle the count reaches N (registered next state); go to CALC.
  - in_valid low stalls with no change.
- CALC (1 cycle):
  - Sxx = N*Σx² − (Σx)²; Sxy = N*Σxy − Σx*Σy. Both signed PW-bit, no overflow by construction.
- DIV1:
  - Sxx≠0: b1 = (Sxy<<FRAC)/Sxx through the divider.
  - Sxx=0: skip the divide, set b1=0 and err_div0=1, go to MUL.
- MUL (1 cycle): num0 = (Σy<<FRAC) − b1*Σx, signed B0W.
- DIV0: b0 = num0/N through the divider.
- DONE:
  - out_valid=1; b0, b1 and err_div0 stable.
  - On out_valid & out_ready: go to IDLE next cycle and clear out_valid. Outputs keep their last values.
- Division:
  - Unsigned magnitudes, sign = XOR of operand signs, quotient truncated toward zero.
  - Divider takes DVW cycles after its start pulse, then pulses done.
- Latency:
  - Last sample accepted to out_valid = 2*DVW+5 cycles for nominal Sxx≠0.
  - When Sxx=0 the DIV1 divide is skipped, so latency is DVW+4 cycles.
- Outputs are registered. No combinational path from in_valid/out_ready to any output except the state-registered in_ready.

Decomposition:
- Package linreg_pkg holds:
  - derived width localparams (CW, SW, QW, PW, DVW, B1W, B0W) as functions of DW/N_MAX/FRAC;
  - the FSM state enum;
  - the sign/magnitude helper functions.
- One sub-module: seq_div, a parametrised (W) restoring divider.
  - Ports: clk, rst, start, dividend, divisor, quotient, done; one quotient bit per cycle.
  - Shared by DIV1 and DIV0.

Test Plan:
- N=4, (x,y)=(1,3),(2,5),(3,7),(4,9) -> b1=2048, b0=1024, err_div0=0.
- N=3, (1,6),(2,4),(3,2) -> b1=−2048, b0=8192 (signed negative slope).
- N=3, (0,0),(1,1),(2,1) -> b1=512, b0=170 (truncation toward zero).
- N=2, (5,1),(5,2) -> err_div0=1, b1=0, b0=1536. Also n_samples=0 -> DONE directly with err_div0=1, b0=b1=0.
- Handshake case, N=4 vector with:
  - in_valid toggled randomly;
  - out_ready held low 10 cycles;
  - start pulsed during ACC.
  - Required: results identical to the first scenario, outputs stable while out_ready=0, the extra start ignored, and latency counted as specified.
- Reset mid-DIV1 -> all outputs 0 and IDLE next cycle. A following clean job reproduces the first scenario.

Source files
------------

// File: rtl/linreg_pkg.sv
// Shared widths, FSM state type and sign/magnitude helpers for the linear-regression engine.
// Widths derive from DW, N_MAX and FRAC; change those three to re-size the whole slice.
package linreg_pkg;
    localparam int DW    = 20;
    localparam int N_MAX = 256;
    localparam int FRAC  = 10;
    localparam int CW    = $clog2(N_MAX + 1);
    localparam int SW    = DW + CW;
    localparam int QW    = 2 * DW + CW;
    localparam int PW    = 2 * DW + 2 * CW + 1;
    localparam int DVW   = PW + FRAC;
    localparam int B1W   = DVW;
    localparam int B0W   = B1W + SW + 1;

    typedef enum logic [2:0] {
        IDLE, ACC, CALC, DIV1, MUL, DIV0, DONE
    } state_t;

    function automatic logic [B0W-1:0] f_mag(input logic signed [B0W-1:0] v);
        return v[B0W-1] ? B0W'(-v) : B0W'(v);
    endfunction

    function automatic logic signed [B0W-1:0] f_apply_sign(input logic [B0W-1:0] m, input logic neg);
        return neg ? -$signed(m) : $signed(m);
    endfunction
endpackage

// File: rtl/linreg_engine_if.sv
// Job, sample and result signals between source/consumer (master) and the engine (slave).
interface linreg_engine_if;
    import linreg_pkg::*;

    // A sample moves on a clock edge where in_valid & in_ready; a result is consumed on
    // out_valid & out_ready. The side holding valid keeps its data stable until it is taken.
    logic                  start;
    logic [CW-1:0]         n_samples;
    logic                  in_valid;
    logic                  in_ready;
    logic [DW-1:0]         xi;
    logic [DW-1:0]         yi;
    logic                  busy;
    logic                  out_valid;
    logic                  out_ready;
    logic signed [B1W-1:0] b1;
    logic signed [B0W-1:0] b0;
    logic                  err_div0;

    modport slave (
        input  start, n_samples, in_valid, xi, yi, out_ready,
        output in_ready, busy, out_valid, b1, b0, err_div0
    );

    modport master (
        output start, n_samples, in_valid, xi, yi, out_ready,
        input  in_ready, busy, out_valid, b1, b0, err_div0
    );
endinterface

// File: rtl/linreg_engine_div.sv
// Unsigned restoring divider: W cycles after a start pulse, done pulses for one cycle
// with the quotient valid. A start while busy restarts the operation.
module seq_div #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic         done
);
    localparam int CNTW = $clog2(W + 1);

    logic [W-1:0]    r_q;
    logic [W-1:0]    r_rem;
    logic [W-1:0]    r_d;
    logic [CNTW-1:0] r_cnt;
    logic            r_busy;
    logic            r_done;
    logic [W:0]      w_shift;
    logic [W:0]      w_diff;

    // Remainder stays below the divisor, so a borrow shows up in the top bit of w_diff.
    assign w_shift = {r_rem, r_q[W-1]};
    assign w_diff  = w_shift - {1'b0, r_d};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q    <= '0;
            r_rem  <= '0;
            r_d    <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_q    <= dividend;
                r_rem  <= '0;
                r_d    <= divisor;
                r_cnt  <= CNTW'(W);
                r_busy <= 1'b1;
            end else if (r_busy) begin
                if (!w_diff[W]) begin
                    r_rem <= w_diff[W-1:0];
                    r_q   <= {r_q[W-2:0], 1'b1};
                end else begin
                    r_rem <= w_shift[W-1:0];
                    r_q   <= {r_q[W-2:0], 1'b0};
                end
                r_cnt <= r_cnt - CNTW'(1);
                if (r_cnt == CNTW'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign quotient = r_q;
    assign done     = r_done;
endmodule

// File: rtl/linreg_engine.sv
// Least-squares slope/intercept engine: accumulates N samples, then computes
// b1 = (Sxy<<FRAC)/Sxx and b0 = ((Sy<<FRAC) - b1*Sx)/N on one shared divider.
module linreg_engine
    import linreg_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    linreg_engine_if.slave bus,
    output state_t         o_state
);
    state_t                r_state, w_state_n;
    logic [CW-1:0]         r_n, r_cnt;
    logic [SW-1:0]         r_sum_x, r_sum_y;
    logic [QW-1:0]         r_sum_xx, r_sum_xy;
    logic signed [PW-1:0]  r_sxx, r_sxy;
    logic signed [B1W-1:0] r_b1;
    logic signed [B0W-1:0] r_b0;
    logic                  r_err, r_neg, r_div_issued;

    logic signed [PW-1:0]  w_sxx, w_sxy;
    logic signed [B0W-1:0] w_num0;
    logic [DVW-1:0]        w_div_dividend, w_div_divisor, w_div_q;
    logic                  w_div_neg, w_div_start, w_div_done;

    assign w_sxx  = $signed(PW'(r_n) * PW'(r_sum_xx) - PW'(r_sum_x) * PW'(r_sum_x));
    assign w_sxy  = $signed(PW'(r_n) * PW'(r_sum_xy) - PW'(r_sum_x) * PW'(r_sum_y));
    assign w_num0 = ($signed(B0W'(r_sum_y)) <<< FRAC) - B0W'(r_b1) * $signed(B0W'(r_sum_x));

    // MUL launches the intercept divide; every other launch is the slope divide.
    always_comb begin
        w_div_dividend = '0;
        w_div_divisor  = '0;
        w_div_neg      = 1'b0;
        if (r_state == MUL) begin
            w_div_dividend = DVW'(f_mag(w_num0));
            w_div_divisor  = DVW'(r_n);
            w_div_neg      = w_num0[B0W-1];
        end else begin
            w_div_dividend = DVW'(f_mag(B0W'(r_sxy) <<< FRAC));
            w_div_divisor  = DVW'(f_mag(B0W'(r_sxx)));
            w_div_neg      = r_sxy[PW-1] ^ r_sxx[PW-1];
        end
    end

    seq_div #(.W(DVW)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (w_div_start),
        .dividend (w_div_dividend),
        .divisor  (w_div_divisor),
        .quotient (w_div_q),
        .done     (w_div_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_n;
    end

    always_comb begin
        w_state_n   = r_state;
        w_div_start = 1'b0;
        case (r_state)
            IDLE: if (bus.start) w_state_n = (bus.n_samples == '0) ? DONE : ACC;
            ACC:  if (bus.in_valid && r_cnt == r_n - CW'(1)) w_state_n = CALC;
            CALC: w_state_n = DIV1;
            DIV1: begin
                if (!r_div_issued) begin
                    if (r_sxx == '0) w_state_n = MUL;
                    else             w_div_start = 1'b1;
                end else if (w_div_done) begin
                    w_state_n = MUL;
                end
            end
            MUL: begin
                w_div_start = 1'b1;
                w_state_n   = DIV0;
            end
            DIV0: if (w_div_done) w_state_n = DONE;
            DONE: if (bus.out_ready) w_state_n = IDLE;
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_n <= '0; r_cnt <= '0;
            r_sum_x <= '0; r_sum_y <= '0; r_sum_xx <= '0; r_sum_xy <= '0;
            r_sxx <= '0; r_sxy <= '0; r_b1 <= '0; r_b0 <= '0;
            r_err <= 1'b0; r_neg <= 1'b0; r_div_issued <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (bus.start) begin
                    if (bus.n_samples == '0) begin
                        r_b1 <= '0; r_b0 <= '0; r_err <= 1'b1;
                    end else begin
                        r_sum_x <= '0; r_sum_y <= '0; r_sum_xx <= '0; r_sum_xy <= '0;
                        r_cnt <= '0; r_n <= bus.n_samples; r_err <= 1'b0;
                    end
                end
                ACC: if (bus.in_valid) begin
                    r_sum_x  <= r_sum_x + SW'(bus.xi);
                    r_sum_y  <= r_sum_y + SW'(bus.yi);
                    r_sum_xx <= r_sum_xx + QW'(bus.xi) * QW'(bus.xi);
                    r_sum_xy <= r_sum_xy + QW'(bus.xi) * QW'(bus.yi);
                    r_cnt    <= r_cnt + CW'(1);
                end
                CALC: begin
                    r_sxx <= w_sxx;
                    r_sxy <= w_sxy;
                end
                DIV1: begin
                    if (!r_div_issued) begin
                        if (r_sxx == '0) begin
                            r_b1 <= '0; r_err <= 1'b1;
                        end else begin
                            r_div_issued <= 1'b1;
                        end
                    end else if (w_div_done) begin
                        r_b1         <= B1W'(f_apply_sign(B0W'(w_div_q), r_neg));
                        r_div_issued <= 1'b0;
                    end
                end
                DIV0: if (w_div_done) r_b0 <= f_apply_sign(B0W'(w_div_q), r_neg);
                default: ;
            endcase
            if (w_div_start) r_neg <= w_div_neg;
        end
    end

    assign bus.in_ready  = (r_state == ACC);
    assign bus.busy      = (r_state != IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.b1        = r_b1;
    assign bus.b0        = r_b0;
    assign bus.err_div0  = r_err;
    assign o_state       = r_state;
endmodule
